// File: rtl/btb_predictor.sv
// Set-associative branch target buffer with saturating counters.
// One-cycle lookup beside fetch, trained by execute's resolved branches.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int WAYS    = 2,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - 2 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic             valid_q [SETS][WAYS];
  logic             valid_d [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_d   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_q   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_d   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_d   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [WAY_W-1:0] rr_d    [SETS];

  logic            pred_valid_q, pred_valid_d;
  logic            pred_hit_q,   pred_hit_d;
  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, has_free;
  logic [WAY_W-1:0] lk_way, up_way, free_way, victim, rr_next;
  logic             unused_upd_lsb;

  assign lk_idx = lk_pc[2 +: IDX_W];
  assign lk_tag = lk_pc[XLEN-1 -: TAG_W];
  assign up_idx = upd_pc[2 +: IDX_W];
  assign up_tag = upd_pc[XLEN-1 -: TAG_W];
  assign unused_upd_lsb = ^upd_pc[1:0];

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Lookup reads pre-update state; a flush in the same cycle forces a miss.
  always_comb begin
    pred_valid_d  = lk_valid;
    pred_hit_d    = lk_valid & lk_hit & ~flush;
    pred_taken_d  = pred_hit_d & ctr_q[lk_idx][lk_way][CTR_W-1];
    pred_target_d = '0;
    if (pred_hit_d)
      pred_target_d = tgt_q[lk_idx][lk_way];
    else if (lk_valid)
      pred_target_d = lk_pc + XLEN'(4);
  end

  always_comb begin
    up_hit   = 1'b0;
    up_way   = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!valid_q[up_idx][w] && !has_free) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign rr_next = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0
                 : rr_q[up_idx] + WAY_W'(1);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    victim  = has_free ? free_way : rr_q[up_idx];
    if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_d[s][w] = 1'b0;
    end else if (upd_valid && up_hit) begin
      if (upd_taken) begin
        if (ctr_q[up_idx][up_way] != '1)
          ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] + CTR_W'(1);
        tgt_d[up_idx][up_way] = upd_target;
      end else if (ctr_q[up_idx][up_way] != '0) begin
        ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] - CTR_W'(1);
      end
    end else if (upd_valid && upd_taken) begin
      valid_d[up_idx][victim] = 1'b1;
      tag_d[up_idx][victim]   = up_tag;
      tgt_d[up_idx][victim]   = upd_target;
      ctr_d[up_idx][victim]   = CTR_WEAK;
      if (!has_free)
        rr_d[up_idx] = rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          ctr_q[s][w]   <= CTR_INIT;
        end
      end
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      ctr_q         <= ctr_d;
      rr_q          <= rr_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed scenarios plus random traffic
// checked each cycle against a table-of-sets reference model.
module tb_btb_predictor;

  localparam int SETS = 32;
  localparam int NW   = 2;
  localparam int CMAX = 3;
  localparam int CWK  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        flush = 1'b0;

  btb_predictor #(.XLEN(32), .ENTRIES(64), .WAYS(2), .CTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference table
  bit          m_valid [SETS][NW];
  int unsigned m_tag   [SETS][NW];
  logic [31:0] m_tgt   [SETS][NW];
  int          m_ctr   [SETS][NW];
  int          m_rr    [SETS];

  // expectation for the lookup driven this cycle, and the one on show
  bit          pend_en = 0, pend_ctg = 0, pend_lit = 0;
  bit          pend_v = 0, pend_h = 0, pend_t = 0;
  logic [31:0] pend_tg = '0;
  bit          pend_lv = 0, pend_lh = 0, pend_lt = 0;
  logic [31:0] pend_ltg = '0;
  bit          cur_en = 0, cur_ctg = 0, cur_lit = 0;
  bit          cur_v = 0, cur_h = 0, cur_t = 0;
  logic [31:0] cur_tg = '0;
  bit          cur_lv = 0, cur_lh = 0, cur_lt = 0;
  logic [31:0] cur_ltg = '0;

  bit          lit_arm = 0, lit_v = 0, lit_h = 0, lit_t = 0;
  logic [31:0] lit_tg = '0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int set_of(logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc >> 7;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_ctr[s][w]   = 1;
      end
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                   output bit tk, output logic [31:0] tg);
    int s = set_of(pc);
    hit = 0;
    tk  = 0;
    tg  = pc + 32'd4;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
        hit = 1;
        tk  = (m_ctr[s][w] >= CWK);
        tg  = m_tgt[s][w];
      end
  endfunction

  function automatic void m_update(input logic [31:0] pc,
                                   input logic [31:0] tg, input bit tk);
    int s  = set_of(pc);
    int hw = -1;
    int fw = -1;
    int v;
    for (int w = 0; w < NW; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) hw = w;
      if (!m_valid[s][w] && fw < 0) fw = w;
    end
    if (hw >= 0) begin
      if (tk) begin
        if (m_ctr[s][hw] < CMAX) m_ctr[s][hw]++;
        m_tgt[s][hw] = tg;
      end else if (m_ctr[s][hw] > 0) begin
        m_ctr[s][hw]--;
      end
    end else if (tk) begin
      if (fw >= 0) v = fw;
      else begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NW;
      end
      m_valid[s][v] = 1;
      m_tag[s][v]   = tag_of(pc);
      m_tgt[s][v]   = tg;
      m_ctr[s][v]   = CWK;
    end
  endfunction

  task automatic lit(input bit v, input bit h, input bit t,
                     input logic [31:0] tg);
    lit_arm = 1;
    lit_v = v; lit_h = h; lit_t = t; lit_tg = tg;
  endtask

  task automatic step(input bit rs, input bit lkv, input logic [31:0] lkpc,
                      input bit uv, input logic [31:0] upc,
                      input logic [31:0] utg, input bit utk, input bit fl);
    bit h, t;
    logic [31:0] tg;
    @(negedge clk);
    rst = rs; lk_valid = lkv; lk_pc = lkpc;
    upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = utk;
    flush = fl;
    pend_en  = 1;
    pend_lit = lit_arm;
    pend_lv = lit_v; pend_lh = lit_h; pend_lt = lit_t; pend_ltg = lit_tg;
    lit_arm = 0;
    pend_ctg = !fl || !rs;
    if (!rs) begin
      pend_v = 0; pend_h = 0; pend_t = 0; pend_tg = '0;
      m_reset();
    end else begin
      m_lookup(lkpc, h, t, tg);
      pend_v  = lkv;
      pend_h  = lkv && h && !fl;
      pend_t  = lkv && t && !fl;
      pend_tg = lkv ? tg : 32'd0;
      if (fl) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < NW; w++)
            m_valid[s][w] = 0;
      end else if (uv) begin
        m_update(upc, utg, utk);
      end
    end
  endtask

  task automatic look(input logic [31:0] pc);
    step(1, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tg,
                     input bit tk);
    step(1, 0, 0, 1, pc, tg, tk, 0);
  endtask

  always @(posedge clk) begin
    cur_en <= pend_en; cur_ctg <= pend_ctg; cur_lit <= pend_lit;
    cur_v <= pend_v; cur_h <= pend_h; cur_t <= pend_t; cur_tg <= pend_tg;
    cur_lv <= pend_lv; cur_lh <= pend_lh; cur_lt <= pend_lt;
    cur_ltg <= pend_ltg;
  end

  always @(negedge clk) begin
    if (cur_en) begin
      chk("pred_valid", pred_valid, cur_v);
      chk("pred_hit", pred_hit, cur_h);
      chk("pred_taken", pred_taken, cur_t);
      if (cur_ctg) chk("pred_target", pred_target, cur_tg);
      if (cur_lit) begin
        chk("lit_valid", pred_valid, cur_lv);
        chk("lit_hit", pred_hit, cur_lh);
        chk("lit_taken", pred_taken, cur_lt);
        chk("model_lit_hit", cur_h, cur_lh);
        chk("model_lit_taken", cur_t, cur_lt);
        if (cur_ctg) begin
          chk("lit_target", pred_target, cur_ltg);
          chk("model_lit_target", cur_tg, cur_ltg);
        end
      end
    end
  end

  function automatic logic [31:0] rpc();
    int i;
    if ($urandom_range(0, 7) == 0) return $urandom;
    i = $urandom_range(0, 2);
    return (32'($urandom_range(0, 3)) << 7) |
           (32'((i == 2) ? 31 : i) << 2);
  endfunction

  initial begin
    logic [31:0] a, b;
    m_reset();
    // reset with a lookup pending produces no prediction
    lit(0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    lit(1, 0, 0, 32'h104);
    look(32'h100);
    lit(1, 0, 0, 32'h0);
    look(32'hFFFF_FFFC);
    upd(32'h100, 32'h200, 1);
    lit(1, 1, 1, 32'h200);
    look(32'h100);
    for (int k = 0; k < 4; k++) upd(32'h100, 32'h300, 0);
    lit(1, 1, 0, 32'h200);
    look(32'h100);
    for (int k = 0; k < 2; k++) upd(32'h100, 32'h200, 1);
    lit(1, 1, 1, 32'h200);
    look(32'h100);
    for (int k = 0; k < 3; k++) upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h200, 0);
    lit(1, 1, 1, 32'h200);
    look(32'h100);
    upd(32'h100, 32'h200, 0);
    lit(1, 1, 0, 32'h200);
    look(32'h100);
    // round-robin replacement in set 0
    step(0, 0, 0, 0, 0, 0, 0, 0);
    upd(32'h100, 32'h1A0, 1);
    upd(32'h180, 32'h1B0, 1);
    upd(32'h200, 32'h1C0, 1);
    upd(32'h280, 32'h1D0, 1);
    lit(1, 0, 0, 32'h104); look(32'h100);
    lit(1, 0, 0, 32'h184); look(32'h180);
    lit(1, 1, 1, 32'h1C0); look(32'h200);
    lit(1, 1, 1, 32'h1D0); look(32'h280);
    upd(32'h300, 32'h1E0, 1);
    lit(1, 0, 0, 32'h204); look(32'h200);
    lit(1, 1, 1, 32'h1D0); look(32'h280);
    // same-cycle update and lookup
    step(0, 0, 0, 0, 0, 0, 0, 0);
    lit(1, 0, 0, 32'h104);
    step(1, 1, 32'h100, 1, 32'h100, 32'h300, 1, 0);
    lit(1, 1, 1, 32'h300);
    look(32'h100);
    // flush beats a same-cycle update and forces the lookup to miss
    lit(1, 0, 0, 32'h0);
    step(1, 1, 32'h100, 1, 32'h180, 32'h400, 1, 1);
    lit(1, 0, 0, 32'h104); look(32'h100);
    lit(1, 0, 0, 32'h184); look(32'h180);
    lit(0, 0, 0, 32'h0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      a = rpc();
      b = ($urandom_range(0, 3) == 0) ? a : rpc();
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, a,
           $urandom_range(0, 1) == 1, b, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
